// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle-encoded event decoder.
package toggle_pkg;

    typedef enum logic {INIT, RUN} state_e;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned PEND_MAX_DEF    = 4;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned PEND_W          = 3;
    localparam int unsigned INIT_CNT_W      = 3;

endpackage

// File: rtl/toggle_decoder_if.sv
// Event-side bundle of the toggle decoder: toggle line in, event handshake and status out.
interface toggle_decoder_if import toggle_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic              t_in;
    logic              evt_valid;
    logic              evt_ready;
    logic [PEND_W-1:0] pend_count;
    logic [CNT_W-1:0]  evt_count;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        output t_in,
        output evt_ready,
        output clr_ovf,
        input  evt_valid,
        input  pend_count,
        input  evt_count,
        input  overflow
    );

    modport slave (
        input  t_in,
        input  evt_ready,
        input  clr_ovf,
        output evt_valid,
        output pend_count,
        output evt_count,
        output overflow
    );

endinterface

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer bringing the asynchronous toggle line into the clk domain.
module toggle_sync import toggle_pkg::*; #(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Turns each level change on t_in into one queued event with a valid/ready pop interface.
module toggle_decoder import toggle_pkg::*; #(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned PEND_MAX    = PEND_MAX_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input logic             clk,
    input logic             reset,
    toggle_decoder_if.slave bus
);

    localparam logic [PEND_W-1:0]     PendMax  = PEND_W'(PEND_MAX);
    localparam logic [INIT_CNT_W-1:0] InitLast = INIT_CNT_W'(SYNC_STAGES);

    logic sync_q;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (bus.t_in),
        .q_o  (sync_q)
    );

    state_e                state_q, state_d;
    logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic                  last_q;
    logic [PEND_W-1:0]     pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  detect;
    logic                  pop;
    logic                  drop;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        drop       = 1'b0;
        detect     = (state_q == RUN) && (sync_q != last_q);
        pop        = valid_q & bus.evt_ready;

        // INIT lets last_q settle onto the synchronized reset-release level.
        if (state_q == INIT) begin
            if (init_cnt_q == InitLast) begin
                state_d = RUN;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end

        if (detect) begin
            cnt_d = cnt_q + 1'b1;
            if (!pop) begin
                if (pend_q < PendMax) begin
                    pend_d = pend_q + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end else if (pop) begin
            pend_d = pend_q - 1'b1;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end

        valid_d = (pend_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            last_q     <= 1'b0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_q     <= sync_q;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.evt_valid  = valid_q;
    assign bus.pend_count = pend_q;
    assign bus.evt_count  = cnt_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed scoreboard bench: default-sized decoder plus a 3-bit-counter instance for wrap.
module tb_toggle_decoder;
    import toggle_pkg::*;

    localparam int PendMaxTb = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    toggle_decoder_if #(.CNT_W(8)) ia ();
    toggle_decoder_if #(.CNT_W(3)) ib ();

    toggle_decoder #(
        .SYNC_STAGES(2),
        .PEND_MAX   (4),
        .CNT_W      (8)
    ) u_dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ia.slave)
    );

    toggle_decoder #(
        .SYNC_STAGES(2),
        .PEND_MAX   (4),
        .CNT_W      (3)
    ) u_dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ib.slave)
    );

    int   checks  = 0;
    int   errors  = 0;
    int   sb_q[$];
    int   next_id = 0;
    int   exp_cnt = 0;
    logic exp_ovf = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one toggle on instance A and record the expected pending entry (evt_ready low).
    task automatic toggle_a();
        ia.t_in = ~ia.t_in;
        exp_cnt++;
        if (sb_q.size() < PendMaxTb) begin
            sb_q.push_back(next_id);
            next_id++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic pop_a(input string tag);
        chk({tag, "_valid"}, 32'(ia.evt_valid), 32'd1);
        ia.evt_ready = 1'b1;
        tick();
        ia.evt_ready = 1'b0;
        chk({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        chk({tag, "_pend"}, 32'(ia.pend_count), 32'(sb_q.size()));
    endtask

    task automatic check_a(input string tag);
        chk({tag, "_pend"}, 32'(ia.pend_count), 32'(sb_q.size()));
        chk({tag, "_valid"}, 32'(ia.evt_valid), 32'(sb_q.size() != 0));
        chk({tag, "_cnt"}, 32'(ia.evt_count), 32'(exp_cnt));
        chk({tag, "_ovf"}, 32'(ia.overflow), 32'(exp_ovf));
    endtask

    initial begin
        logic seen;
        ia.t_in      = 1'b1;
        ia.evt_ready = 1'b0;
        ia.clr_ovf   = 1'b0;
        ib.t_in      = 1'b0;
        ib.evt_ready = 1'b0;
        ib.clr_ovf   = 1'b0;

        // Reset held with t_in high; release must not produce an event.
        tick();
        tick();
        check_a("rst_a");
        chk("rst_b_cnt", 32'(ib.evt_count), 32'd0);
        chk("rst_b_valid", 32'(ib.evt_valid), 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | ia.evt_valid;
        end
        chk("release_no_evt", 32'(seen), 32'd0);
        check_a("release");

        // Falling transition, then latency and single pop.
        toggle_a();
        tick();
        chk("fall_lat_e1", 32'(ia.evt_valid), 32'd0);
        tick();
        chk("fall_lat_e2", 32'(ia.evt_valid), 32'd0);
        tick();
        chk("fall_lat_e3", 32'(ia.evt_valid), 32'd1);
        check_a("fall");
        pop_a("fall_pop");
        chk("fall_pop_valid0", 32'(ia.evt_valid), 32'd0);

        // evt_ready without evt_valid has no effect.
        ia.evt_ready = 1'b1;
        tick();
        tick();
        ia.evt_ready = 1'b0;
        check_a("idle_ready");

        // Rising transition with the same latency.
        toggle_a();
        tick();
        tick();
        chk("rise_lat_e2", 32'(ia.evt_valid), 32'd0);
        tick();
        chk("rise_lat_e3", 32'(ia.evt_valid), 32'd1);
        check_a("rise");
        pop_a("rise_pop");
        check_a("rise_drained");

        // Five toggles with no consumer: fill to PEND_MAX and overflow.
        for (int i = 0; i < 5; i++) begin
            toggle_a();
            repeat (4) tick();
        end
        check_a("fill");
        repeat (3) tick();
        chk("ovf_sticky", 32'(ia.overflow), 32'd1);
        ia.clr_ovf = 1'b1;
        tick();
        ia.clr_ovf = 1'b0;
        exp_ovf    = 1'b0;
        check_a("clr_ovf");

        // Drop and clear on the same cycle: set wins.
        toggle_a();
        tick();
        tick();
        ia.clr_ovf = 1'b1;
        tick();
        ia.clr_ovf = 1'b0;
        check_a("set_wins");
        ia.clr_ovf = 1'b1;
        tick();
        ia.clr_ovf = 1'b0;
        exp_ovf    = 1'b0;
        check_a("clr_again");

        // Full queue, pop coincides with detect: count stays, no overflow.
        ia.t_in = ~ia.t_in;
        exp_cnt++;
        tick();
        tick();
        ia.evt_ready = 1'b1;
        tick();
        ia.evt_ready = 1'b0;
        void'(sb_q.pop_front());
        sb_q.push_back(next_id);
        next_id++;
        check_a("pop_detect");

        for (int i = 0; i < 4; i++) pop_a("drain");
        check_a("drained");

        // Reset mid-operation discards pending events immediately.
        toggle_a();
        repeat (4) tick();
        toggle_a();
        repeat (4) tick();
        check_a("two_pend");
        reset = 1'b1;
        #1;
        sb_q.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        check_a("async_rst");
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check_a("reinit");
        toggle_a();
        repeat (4) tick();
        check_a("post_rst_evt");
        repeat (4) tick();
        check_a("post_rst_once");
        pop_a("post_rst_pop");

        // Instance B: nine events with a ready consumer, 3-bit counter wraps.
        ib.evt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ib.t_in = ~ib.t_in;
            repeat (3) tick();
            chk("b_valid_rise", 32'(ib.evt_valid), 32'd1);
            tick();
            chk("b_popped", 32'(ib.pend_count), 32'd0);
        end
        ib.evt_ready = 1'b0;
        repeat (2) tick();
        chk("b_wrap_cnt", 32'(ib.evt_count), 32'd1);
        chk("b_pend", 32'(ib.pend_count), 32'd0);
        chk("b_valid", 32'(ib.evt_valid), 32'd0);
        chk("b_ovf", 32'(ib.overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
